// File: rtl/kernel_adapter_mchan_pkg.sv
// Shared types and defaults for the multi-channel HWPE kernel adapter.
// Optional build macro used by the top: KERNEL_ADAPTER_MCHAN_PERF_EN.
package kernel_adapter_mchan_package;

  localparam int KA_MCHAN_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_kernel_adapter_mchan_e;

  typedef struct packed {
    logic ready;
    logic done;
    logic idle;
  } flags_kernel_adapter_mchan_t;

  typedef struct packed {
    logic start;
    logic clear;
  } ctrl_kernel_adapter_mchan_t;

endpackage

// File: rtl/kernel_adapter_mchan_chan_cnt.sv
// Per-channel transfer counter: samples its quota on load, counts enabled
// beats and saturates at the quota; met is high whenever count equals quota.
module kernel_adapter_mchan_chan_cnt
  import kernel_adapter_mchan_package::*;
#(
  parameter int CNT_W = KA_MCHAN_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load,
  input  logic             clear,
  input  logic [CNT_W-1:0] max,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             open,
  output logic             met
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] max_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      max_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
      max_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
      max_q <= max;
    end else if (en && !met) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A zero quota is met from the first cycle of the job.
  assign met  = (cnt_q == max_q);
  assign open = (cnt_q < max_q);
  assign cnt  = cnt_q;

endmodule

// File: rtl/kernel_adapter_mchan.sv
// Multi-channel kernel adapter: gates N_IN sink channels against a run FSM,
// passes N_OUT source channels through, counts beats against per-job quotas.
// Optional perf counters under KERNEL_ADAPTER_MCHAN_PERF_EN.
//
// Handshake: a beat transfers on a channel in the cycle where valid and ready
// are both high at the clock edge; valid never waits on ready. Input channels
// are only opened (ready/valid forwarded) in RUN while below quota.
module kernel_adapter_mchan
  import kernel_adapter_mchan_package::*;
#(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 1,
  parameter int DATA_W = 32,
  parameter int CNT_W  = KA_MCHAN_CNT_W
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    test_mode_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [N_IN*CNT_W-1:0]   in_max_i,
  input  logic [N_OUT*CNT_W-1:0]  out_max_i,
  input  logic [N_IN-1:0]         in_valid_i,
  input  logic [N_IN*DATA_W-1:0]  in_data_i,
  output logic [N_IN-1:0]         in_ready_o,
  output logic [N_IN-1:0]         k_in_valid_o,
  output logic [N_IN*DATA_W-1:0]  k_in_data_o,
  input  logic [N_IN-1:0]         k_in_ready_i,
  input  logic [N_OUT-1:0]        k_out_valid_i,
  input  logic [N_OUT*DATA_W-1:0] k_out_data_i,
  output logic [N_OUT-1:0]        k_out_ready_o,
  output logic [N_OUT-1:0]        out_valid_o,
  output logic [N_OUT*DATA_W-1:0] out_data_o,
  input  logic [N_OUT-1:0]        out_ready_i,
  output logic                    flag_ready_o,
  output logic                    flag_done_o,
  output logic                    flag_idle_o,
  output logic [N_IN*CNT_W-1:0]   in_cnt_o,
  output logic [N_OUT*CNT_W-1:0]  out_cnt_o,
  output logic [1:0]              state_o
`ifdef KERNEL_ADAPTER_MCHAN_PERF_EN
  ,
  output logic [31:0]             busy_cycles_o,
  output logic [31:0]             in_stall_cycles_o
`endif
);

  state_kernel_adapter_mchan_e state_q;
  flags_kernel_adapter_mchan_t flags_q;
  ctrl_kernel_adapter_mchan_t  ctrl;

  logic [N_IN-1:0]  in_open, in_met, in_gate, in_fire;
  logic [N_OUT-1:0] unused_out_open, out_met, out_fire;
  logic             run, active, all_in_met, all_out_met;
  logic             unused_test_mode;

  assign unused_test_mode = test_mode_i;

  // Start is only honoured in IDLE, and never alongside an abort.
  always_comb begin
    ctrl       = '0;
    ctrl.clear = clear_i;
    ctrl.start = start_i && (state_q == ST_IDLE) && !clear_i;
  end

  assign run    = (state_q == ST_RUN);
  assign active = (state_q != ST_IDLE);

  assign in_gate      = in_open & {N_IN{run}};
  assign k_in_valid_o = in_valid_i & in_gate;
  assign in_ready_o   = k_in_ready_i & in_gate;
  assign k_in_data_o  = in_data_i;
  assign in_fire      = in_valid_i & in_ready_o;

  // Output side is never gated so the kernel can always drain.
  assign out_valid_o   = k_out_valid_i;
  assign out_data_o    = k_out_data_i;
  assign k_out_ready_o = out_ready_i;
  assign out_fire      = k_out_valid_i & out_ready_i & {N_OUT{active}};

  for (genvar i = 0; i < N_IN; i++) begin : g_in_cnt
    kernel_adapter_mchan_chan_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .load  (ctrl.start),
      .clear (ctrl.clear),
      .max   (in_max_i[i*CNT_W +: CNT_W]),
      .en    (in_fire[i]),
      .cnt   (in_cnt_o[i*CNT_W +: CNT_W]),
      .open  (in_open[i]),
      .met   (in_met[i])
    );
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out_cnt
    kernel_adapter_mchan_chan_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .load  (ctrl.start),
      .clear (ctrl.clear),
      .max   (out_max_i[j*CNT_W +: CNT_W]),
      .en    (out_fire[j]),
      .cnt   (out_cnt_o[j*CNT_W +: CNT_W]),
      .open  (unused_out_open[j]),
      .met   (out_met[j])
    );
  end

  assign all_in_met  = &in_met;
  assign all_out_met = &out_met;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      flags_q <= '{ready: 1'b0, done: 1'b0, idle: 1'b1};
    end else begin
      flags_q.ready <= 1'b0;
      flags_q.done  <= 1'b0;
      if (ctrl.clear) begin
        state_q      <= ST_IDLE;
        flags_q.idle <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ctrl.start) begin
              state_q      <= ST_RUN;
              flags_q.idle <= 1'b0;
            end
          end
          ST_RUN: begin
            if (all_in_met) begin
              state_q       <= ST_DRAIN;
              flags_q.ready <= 1'b1;
            end
          end
          ST_DRAIN: begin
            if (all_out_met) begin
              state_q      <= ST_IDLE;
              flags_q.done <= 1'b1;
              flags_q.idle <= 1'b1;
            end
          end
          default: begin
            state_q      <= ST_IDLE;
            flags_q.idle <= 1'b1;
          end
        endcase
      end
    end
  end

  assign flag_ready_o = flags_q.ready;
  assign flag_done_o  = flags_q.done;
  assign flag_idle_o  = flags_q.idle;
  assign state_o      = state_q;

`ifdef KERNEL_ADAPTER_MCHAN_PERF_EN
  logic [31:0] busy_q, stall_q;
  logic        stall;

  assign stall = |(in_gate & in_valid_i & ~k_in_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else if (ctrl.start || ctrl.clear) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      if (active && (busy_q != '1)) busy_q <= busy_q + 1'b1;
      if (stall && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end
  end

  assign busy_cycles_o     = busy_q;
  assign in_stall_cycles_o = stall_q;
`endif

endmodule

// File: doc/kernel_adapter_mchan.md
Name: kernel_adapter_mchan

Overview:
Parametrised multi-channel successor of the single-stream HWPE kernel adapter. Sits between the HWPE streamers and an HLS kernel with N_IN sink and N_OUT source AXI-stream-style channels. Forwards data and gates input admission against a run FSM. Counts per-channel transfers against programmable per-job quotas and raises ready/done/idle flags toward the engine FSM.

Parameters:
N_IN, 2, number of input (sink) channels, 1..8
N_OUT, 1, number of output (source) channels, 1..8
DATA_W, 32, data width per channel
CNT_W, 16, width of per-channel transfer counters and quotas

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
test_mode_i  in  1  test mode, no functional effect
clear_i  in  1  synchronous abort; returns the block to IDLE
start_i  in  1  single-cycle job start
in_max_i  in  N_IN*CNT_W  per-input-channel quota per job; 0 = channel unused
out_max_i  in  N_OUT*CNT_W  per-output-channel quota per job; 0 = channel unused
in_valid_i / in_data_i / in_ready_o  in/in/out  N_IN / N_IN*DATA_W / N_IN  streamer-side sink channels
k_in_valid_o / k_in_data_o / k_in_ready_i  out/out/in  N_IN / N_IN*DATA_W / N_IN  kernel-side inputs
k_out_valid_i / k_out_data_i / k_out_ready_o  in/in/out  N_OUT / N_OUT*DATA_W / N_OUT  kernel-side outputs
out_valid_o / out_data_o / out_ready_i  out/out/in  N_OUT / N_OUT*DATA_W / N_OUT  streamer-side source channels
flag_ready_o  out  1  one-cycle pulse when all input quotas are met
flag_done_o  out  1  one-cycle pulse when all output quotas are met
flag_idle_o  out  1  high in IDLE
in_cnt_o  out  N_IN*CNT_W  live input counters
out_cnt_o  out  N_OUT*CNT_W  live output counters

Behaviour:
- Reset: state IDLE; all counters 0; flag_ready_o=0, flag_done_o=0, flag_idle_o=1.
- Quotas are sampled into internal registers on accepted start_i. Mid-job changes to in_max_i/out_max_i are ignored.
- States: IDLE, RUN, DRAIN.
  - IDLE→RUN on start_i: counters cleared to 0 in the same edge.
  - RUN→DRAIN when every input channel has reached its quota.
  - DRAIN→IDLE when every output channel has reached its quota.
- Input channel i is open when state==RUN and in_cnt[i] < in_max[i]:
  - open: k_in_valid_o[i] = in_valid_i[i] and in_ready_o[i] = k_in_ready_i[i] (combinational, zero latency).
  - not open: k_in_valid_o[i]=0 and in_ready_o[i]=0.
- in_cnt[i] increments on each in_valid_i[i] & in_ready_o[i]. It never exceeds in_max[i].
- Output path: pure combinational pass-through in every state, so the kernel can always drain.
- out_cnt[j] increments on out_valid_o[j] & out_ready_i[j] in RUN or DRAIN, saturating at out_max[j]. Handshakes in IDLE are passed through but not counted.
- flag_ready_o is registered and pulses the cycle after the RUN→DRAIN transition edge.
- flag_done_o is registered and pulses the cycle after the DRAIN→IDLE edge.
- "All met" uses per-channel (cnt==max). A channel with max==0 counts as met immediately.
- Boundary cases:
  - All input quotas 0: RUN→DRAIN one cycle after start.
  - All quotas 0: job completes in 2 cycles with both pulses.
  - Output quota reached while still in RUN: held; DRAIN exits the cycle after entry.
  - start_i outside IDLE: ignored.
  - start_i on the DRAIN→IDLE edge: ignored; must be reissued.
  - clear_i has priority over all events: next state IDLE, counters 0, no flag pulses. Data in flight is not dropped by the adapter.
  - Async reset mid-job returns to reset values immediately.

Optional Feature:
Macro: KERNEL_ADAPTER_MCHAN_PERF_EN.
- Defined: extra outputs busy_cycles_o (32b) and in_stall_cycles_o (32b).
  - busy_cycles_o counts cycles in RUN/DRAIN.
  - in_stall_cycles_o counts cycles where any open channel has in_valid_i=1 and k_in_ready_i=0.
  - Both cleared on start_i or clear_i, saturating at all-ones.
- Not defined: ports absent, no counter logic.

Decomposition:
- Shared package kernel_adapter_mchan_package:
  - state enum (IDLE/RUN/DRAIN), flags_kernel_adapter_mchan_t {ready, done, idle}, ctrl_kernel_adapter_mchan_t {start, clear}
  - default-constant KA_MCHAN_CNT_W.
- One sub-module, kernel_adapter_mchan_chan_cnt: a generated per-channel quota counter with sampled max, an enable and a saturation/met output. It is instantiated N_IN + N_OUT times.

Test Plan:
- N_IN=2, N_OUT=1, in_max={4,4}, out_max=2, kernel always ready, 4 beats per input → flag_ready_o pulses once after the 4th beat on the later channel; 2 outputs → flag_done_o pulses once, idle returns high.
- in_max={3,0}, in_valid_i[0] held high → exactly 3 transfers, then in_ready_o[0]=0 while state stays DRAIN until outputs complete; channel 1 never opens.
- Kernel k_in_ready_i toggling 1010…, quota 8 → in_cnt reaches 8 after 16 cycles, no lost or duplicated beats (scoreboard on data).
- clear_i asserted with in_cnt={2,1} → next cycle IDLE, counters 0, no ready/done pulse; a subsequent start with quota 2 completes normally.
- All quotas 0, start_i → flag_ready_o at cycle +2, flag_done_o at cycle +3 (start edge = cycle 0); start_i repeated during RUN is ignored.
- PERF_EN build: 10-cycle job with 3 stall cycles → busy_cycles_o=10, in_stall_cycles_o=3.
